// File: rtl/fir_mac_sequencer_if.sv
// Start/result signal bundle for fir_mac_sequencer.
// The slave modport is the sequencer side; the master modport is the tap-line/consumer side.
interface fir_mac_sequencer_if #(
  parameter int TOTAL_TAPS   = 9,
  parameter int BITS_PER_TAP = 8,
  parameter int COEF_BITS    = 8,
  parameter int ACC_BITS     = 20
);
  logic                               i_start_calc;
  logic [TOTAL_TAPS*BITS_PER_TAP-1:0] i_taps;
  logic [TOTAL_TAPS*COEF_BITS-1:0]    i_coefs;
  logic                               o_busy;
  logic [ACC_BITS-1:0]                o_value;
  logic                               o_valid;
  logic                               o_overrun;

  modport master (
    output i_start_calc, i_taps, i_coefs,
    input  o_busy, o_value, o_valid, o_overrun
  );

  modport slave (
    input  i_start_calc, i_taps, i_coefs,
    output o_busy, o_value, o_valid, o_overrun
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Serial MAC sequencer for one FIR stage: snapshots the tap window on start,
// then accumulates one signed tap*coef product per clock through a shared multiplier.
module fir_mac_sequencer #(
  parameter int TOTAL_TAPS   = 9,
  parameter int BITS_PER_TAP = 8,
  parameter int TOTAL_BITS   = TOTAL_TAPS * BITS_PER_TAP,
  parameter int COEF_BITS    = 8,
  parameter int ACC_BITS     = 20
) (
  input logic                clk,
  input logic                rst_n,
  fir_mac_sequencer_if.slave bus
);

  localparam int IDX_W     = (TOTAL_TAPS > 1) ? $clog2(TOTAL_TAPS) : 1;
  localparam int PROD_BITS = BITS_PER_TAP + COEF_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_TAPS - 1);

  typedef enum logic {IDLE, MAC} state_t;

  state_t state, next_state;

  logic [IDX_W-1:0]               idx;
  logic signed [ACC_BITS-1:0]     acc;
  logic signed [ACC_BITS-1:0]     acc_sum;
  logic signed [BITS_PER_TAP-1:0] snap     [TOTAL_TAPS];
  logic signed [BITS_PER_TAP-1:0] taps_arr [TOTAL_TAPS];
  logic signed [COEF_BITS-1:0]    coef_arr [TOTAL_TAPS];
  logic signed [BITS_PER_TAP-1:0] tap_cur;
  logic signed [COEF_BITS-1:0]    coef_cur;
  logic signed [PROD_BITS-1:0]    prod;
  logic [TOTAL_BITS-1:0]          taps_flat;
  logic                           last;

  assign taps_flat = bus.i_taps;

  for (genvar k = 0; k < TOTAL_TAPS; k++) begin : g_unpack
    assign taps_arr[k] = taps_flat[k*BITS_PER_TAP +: BITS_PER_TAP];
    assign coef_arr[k] = bus.i_coefs[k*COEF_BITS +: COEF_BITS];
  end

  // Coefficients are read live; only the taps need a snapshot.
  always_comb begin
    tap_cur  = snap[idx];
    coef_cur = coef_arr[idx];
    prod     = tap_cur * coef_cur;
    acc_sum  = acc + ACC_BITS'(prod);
    last     = (idx == LAST_IDX);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.i_start_calc) next_state = MAC;
      MAC:     if (last)             next_state = IDLE;
      default:                       next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      acc           <= '0;
      bus.o_value   <= '0;
      bus.o_valid   <= 1'b0;
      bus.o_overrun <= 1'b0;
      bus.o_busy    <= 1'b0;
      for (int unsigned k = 0; k < TOTAL_TAPS; k++) snap[k] <= '0;
    end else begin
      bus.o_valid   <= 1'b0;
      bus.o_overrun <= 1'b0;
      bus.o_busy    <= (next_state == MAC);
      case (state)
        IDLE: begin
          if (bus.i_start_calc) begin
            snap <= taps_arr;
            acc  <= '0;
            idx  <= '0;
          end
        end
        MAC: begin
          acc           <= acc_sum;
          idx           <= idx + 1'b1;
          bus.o_overrun <= bus.i_start_calc;
          if (last) begin
            bus.o_value <= acc_sum;
            bus.o_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: stimulus pushes expected results and
// overrun strobes into queues, a negedge monitor pops and compares them.
module tb_fir_mac_sequencer;

  localparam int N  = 9;
  localparam int BT = 8;
  localparam int BC = 8;
  localparam int AB = 20;

  typedef int arr_t [N];
  typedef struct { int val; int cyc; } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   busy_cnt;
  int   compared;
  int   mismatched;
  exp_t vq[$];
  int   oq[$];

  fir_mac_sequencer_if #(
    .TOTAL_TAPS  (N),
    .BITS_PER_TAP(BT),
    .COEF_BITS   (BC),
    .ACC_BITS    (AB)
  ) bus ();

  fir_mac_sequencer #(
    .TOTAL_TAPS  (N),
    .BITS_PER_TAP(BT),
    .TOTAL_BITS  (N*BT),
    .COEF_BITS   (BC),
    .ACC_BITS    (AB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    int   oc;
    if (rst_n) begin
      if (bus.o_busy) busy_cnt++;
      if (bus.o_valid) begin
        if (vq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_valid: got o_valid=1 value %0d, expected no result (cycle %0d)",
                   int'($signed(bus.o_value)), cyc);
        end else begin
          e = vq.pop_front();
          check("o_value", int'($signed(bus.o_value)), e.val);
          check("valid_cycle", cyc, e.cyc);
        end
      end
      if (bus.o_overrun) begin
        if (oq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_overrun: got o_overrun=1, expected 0 (cycle %0d)", cyc);
        end else begin
          oc = oq.pop_front();
          check("overrun_cycle", cyc, oc);
        end
      end
    end
  end

  // mode 0: accepted, expect result; 1: dropped, expect overrun; 2: accepted, no result expected
  task automatic issue(input arr_t t, input arr_t c, input int expv, input int mode);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      bus.i_taps[k*BT +: BT]  = t[k][BT-1:0];
      bus.i_coefs[k*BC +: BC] = c[k][BC-1:0];
    end
    bus.i_start_calc = 1'b1;
    if (mode == 0) begin
      e.val = expv;
      e.cyc = cyc + N + 1;
      vq.push_back(e);
    end else if (mode == 1) begin
      oq.push_back(cyc + 1);
    end
    @(negedge clk);
    bus.i_start_calc = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (vq.size() != 0 || oq.size() != 0); i++) @(negedge clk);
    check("pending_results", vq.size(), 0);
    check("pending_overruns", oq.size(), 0);
    vq.delete();
    oq.delete();
    wait_neg(2);
  endtask

  initial begin
    arr_t ramp, ones, m128, p127, sel1, twos, hund;
    ramp = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    ones = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    m128 = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
    p127 = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
    sel1 = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    twos = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    hund = '{100, 100, 100, 100, 100, 100, 100, 100, 100};

    cyc = 0; busy_cnt = 0; compared = 0; mismatched = 0;
    rst_n = 1'b0;
    bus.i_start_calc = 1'b0;
    bus.i_taps  = '0;
    bus.i_coefs = '0;

    wait_neg(3);
    check("reset_o_value", int'(bus.o_value), 0);
    check("reset_o_busy", int'(bus.o_busy), 0);
    check("reset_o_valid", int'(bus.o_valid), 0);
    check("reset_o_overrun", int'(bus.o_overrun), 0);
    rst_n = 1'b1;

    // Single run, accepted at first edge after reset release
    busy_cnt = 0;
    issue(ramp, ones, 45, 0);
    drain();
    check("busy_cycles", busy_cnt, N);

    // Signed extremes
    issue(m128, m128, 147456, 0);
    drain();
    issue(m128, p127, -146304, 0);
    drain();

    // Tap/coef index alignment
    issue(ramp, sel1, 2, 0);
    drain();

    // Overrun at E4 with taps changing after E0
    issue(ramp, ones, 45, 0);
    for (int k = 0; k < N; k++) bus.i_taps[k*BT +: BT] = 8'd100;
    wait_neg(3);
    issue(hund, ones, 0, 1);
    drain();

    // Back-to-back at EN+1, then a start exactly at EN dropped
    issue(ramp, ones, 45, 0);
    wait_neg(9);
    issue(twos, ramp, 90, 0);
    wait_neg(8);
    issue(hund, ramp, 0, 1);
    drain();

    // Reset asserted before E5 aborts the run
    issue(ramp, ones, 0, 2);
    wait_neg(4);
    rst_n = 1'b0;
    wait_neg(2);
    check("abort_o_value", int'(bus.o_value), 0);
    check("abort_o_busy", int'(bus.o_busy), 0);
    rst_n = 1'b1;
    wait_neg(12);
    check("abort_no_valid_queue", vq.size(), 0);
    issue(ramp, sel1, 2, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
